adc_spi_responder: RTL
======================

Name: adc_spi_responder

Overview:
- Synthesizable model of the LTC2308-style 12-bit ADC serial interface; it acts as the slave end of the ADC SPI master.
- It is used on-FPGA as a loopback target and in simulation, standing in for the physical ADC chip.
- It accepts CONVST/SCK/SDI from the master and shifts a 12-bit sample out on SDO, MSB first.
- It decodes the 6-bit config word clocked in on SDI to select the channel for the next conversion.

Parameters:
DATA_W, 12, sample width shifted out per frame
CFG_W, 6, config word width (S/D, O/S, S1, S0, UNI, SLP; first bit on the wire is S/D)
NUM_CH, 8, number of channel inputs
CONV_CYCLES, 80, clk cycles from CONVST rising edge to result ready (1.6 us at 50 MHz)
RESET_CFG, 6'b100010, config word in force after reset (channel 0, unipolar)

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
adc_convst  in  1  conversion start from master (asynchronous to clk)
adc_sck  in  1  SPI clock from master (asynchronous to clk)
adc_sdi  in  1  config bits from master
adc_sdo  out  1  conversion result bits to master
adc_sdo_en  out  1  high while a frame is shifting
ch_data  in  NUM_CH*DATA_W  sample per channel; channel n is at bits [n*DATA_W +: DATA_W]
clr_flags  in  1  synchronous clear for the sticky error flags
busy  out  1  conversion in progress
cfg_word  out  CFG_W  last complete config word received
cfg_valid  out  1  one-clk pulse when cfg_word updates
frame_abort  out  1  sticky; a frame was cut short by CONVST
overrun  out  1  sticky; CONVST rose while busy

Behaviour:
- Reset values: adc_sdo=0, adc_sdo_en=0, busy=0, cfg_word=RESET_CFG, cfg_valid=0, frame_abort=0, overrun=0, state=IDLE. The shift register and bit counter are cleared.
- Reset mid-operation takes effect immediately; no partial config is kept.
- Input synchronization: adc_convst, adc_sck and adc_sdi each pass a 2-flop synchronizer. Rise/fall pulses come from a 3rd flop.
- Event latency: an event is acted on 3 clk after the pin transition. The master's SCK half-period must be at least 4 clk.
- Channel decode: ch = {S1, S0, O/S} = {cfg[3], cfg[2], cfg[4]}. Examples: 100010 gives ch0, 110010 gives ch1, 100110 gives ch2, 110110 gives ch3.
- Only the channel field is decoded; UNI and SLP are stored but not modelled.
- State IDLE: on CONVST rise go to CONV, set busy=1, load the cycle counter with CONV_CYCLES-1.
- State CONV: decrement the counter each clk. At 0, latch ch_data for the channel from the current cfg_word into the result register, set busy=0, go to READY.
- While in CONV, another CONVST rise sets overrun=1 and does not restart the conversion. SCK edges are ignored.
- State READY: on CONVST fall (or CONVST already low), go to SHIFT. Set adc_sdo=result[DATA_W-1], adc_sdo_en=1, bit counter=0.
- State SHIFT, SCK rise: if bit counter < CFG_W, shift adc_sdi into the config shift register. Then increment the bit counter.
- State SHIFT, SCK fall: drive the next result bit, MSB first. Bit index DATA_W-1-count; after all DATA_W bits, drive 0.
- When the CFG_W-th SDI bit has been captured: cfg_word <= shift register, pulse cfg_valid.
- The new config applies to the next conversion, not the one being read.
- End of SHIFT: CONVST rise. If count >= DATA_W, this is a normal end: go to CONV, start a new conversion, adc_sdo_en=0.
- If count < DATA_W when CONVST rises: set frame_abort=1 and still start the conversion.
- On an aborted frame, cfg_word keeps its value if fewer than CFG_W bits were received.
- More than DATA_W SCK edges in a frame: adc_sdo=0 and the counter saturates at DATA_W+CFG_W.
- Simultaneous SCK edge and CONVST rise in the same clk: CONVST takes priority and the SCK edge is dropped.
- clr_flags clears frame_abort and overrun. If an error event occurs in the same cycle as clr_flags, the set wins.
- Arithmetic: the cycle counter is $clog2(CONV_CYCLES) bits. The bit counter is 5 bits, unsigned, and saturating.

Decomposition:
- Shared package adc_spi_pkg holds:
  - state encoding (IDLE, CONV, READY, SHIFT)
  - CFG bit positions (CFG_SD=5, CFG_OS=4, CFG_S1=3, CFG_S0=2, CFG_UNI=1, CFG_SLP=0)
  - RESET_CFG
  - a function mapping a cfg word to a channel index
- One sub-module, sync_edge: a synchronizer plus rise/fall detector, parameterized by stage count. It is instantiated for CONVST, SCK and SDI; the SDI instance uses the level output only.

Test Plan:
- Setup for all scenarios: ch_data ch0=12'hA5C, ch1=12'h3F0, other channels 0; SCK half-period = 10 clk.
- Reset, pulse CONVST, wait for busy to fall, run 12 SCK with SDI=110010. Expect SDO sequence 1010_0101_1100, cfg_word=6'b110010, one cfg_valid pulse.
- Next CONVST plus 12 SCK. Expect SDO = 0011_1111_0000 (ch1) and busy high for 80 clk (+/-3 sync latency).
- Second CONVST rise 20 clk into CONV. Expect overrun=1, busy falls at the original deadline, and the result is unchanged.
- CONVST rise after 4 SCK in a frame. Expect frame_abort=1, cfg_word unchanged, busy=1. Assert clr_flags and expect frame_abort=0.
- Assert reset_n low after 7 SCK. Expect immediately adc_sdo=0, adc_sdo_en=0, cfg_word=6'b100010. The next frame returns ch0 data 12'hA5C.
- 14 SCK in one frame. Expect bits 13-14 on SDO = 0, no extra cfg_valid, and a normal end on CONVST.

Source files
------------

// File: rtl/adc_spi_responder_pkg.sv
// rtl/adc_spi_responder_pkg.sv - shared constants, state encoding and channel decode for the ADC SPI responder
package adc_spi_pkg;

   // Responder state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CONV  = 2'd1;
   localparam logic [1:0] ST_READY = 2'd2;
   localparam logic [1:0] ST_SHIFT = 2'd3;

   // Config word bit positions; S/D is the first bit on the wire
   localparam int CFG_SD  = 5;
   localparam int CFG_OS  = 4;
   localparam int CFG_S1  = 3;
   localparam int CFG_S0  = 2;
   localparam int CFG_UNI = 1;
   localparam int CFG_SLP = 0;

   // Channel 0, unipolar
   localparam logic [5:0] RESET_CFG = 6'b100010;

   // Channel index is {S1, S0, O/S}; the remaining bits do not select a channel
   function automatic logic [2:0] cfg_to_ch(input logic [5:0] cfg);
      return {cfg[CFG_S1], cfg[CFG_S0], cfg[CFG_OS]};
   endfunction

endpackage

// File: rtl/adc_spi_responder_if.sv
// rtl/adc_spi_responder_if.sv - ADC serial pins between the SPI master and the responder
interface adc_spi_responder_if;
   logic adc_convst;
   logic adc_sck;
   logic adc_sdi;
   logic adc_sdo;
   logic adc_sdo_en;

   modport master (
      output adc_convst,
      output adc_sck,
      output adc_sdi,
      input  adc_sdo,
      input  adc_sdo_en
   );

   modport slave (
      input  adc_convst,
      input  adc_sck,
      input  adc_sdi,
      output adc_sdo,
      output adc_sdo_en
   );
endinterface

// File: rtl/adc_spi_responder_sync_edge.sv
// rtl/adc_spi_responder_sync_edge.sv - multi-flop synchronizer with rise/fall pulse detection
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              last_q;

   // Shift the pin through the synchronizer chain and keep one extra flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         last_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~last_q;
   assign fall_o  = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - LTC2308-style ADC serial slave: conversion timing, config capture, result shift-out
module adc_spi_responder #(
   parameter int               DATA_W      = 12,
   parameter int               CFG_W       = 6,
   parameter int               NUM_CH      = 8,
   parameter int               CONV_CYCLES = 80,
   parameter logic [CFG_W-1:0] RESET_CFG   = adc_spi_pkg::RESET_CFG
) (
   input  logic                     clk,
   input  logic                     reset_n,
   adc_spi_responder_if.slave       adc,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic                     clr_flags,
   output logic                     busy,
   output logic [CFG_W-1:0]         cfg_word,
   output logic                     cfg_valid,
   output logic                     frame_abort,
   output logic                     overrun
);
   import adc_spi_pkg::*;

   localparam int CC_W  = $clog2(CONV_CYCLES);
   localparam int BC_W  = 5;
   localparam int IDX_W = $clog2(DATA_W);

   localparam logic [CC_W-1:0]  CC_LOAD     = CC_W'(CONV_CYCLES - 1);
   localparam logic [CC_W-1:0]  CC_ONE      = CC_W'(1);
   localparam logic [BC_W-1:0]  BC_ONE      = BC_W'(1);
   localparam logic [BC_W-1:0]  BC_CFG      = BC_W'(CFG_W);
   localparam logic [BC_W-1:0]  BC_CFG_LAST = BC_W'(CFG_W - 1);
   localparam logic [BC_W-1:0]  BC_DATA     = BC_W'(DATA_W);
   localparam logic [BC_W-1:0]  BC_MAX      = BC_W'(DATA_W + CFG_W);
   localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(DATA_W - 1);

   logic convst_lvl, convst_rise, convst_fall_unused;
   logic sck_lvl_unused, sck_rise, sck_fall;
   logic sdi_lvl, sdi_rise_unused, sdi_fall_unused;

   sync_edge #(.STAGES(2)) u_sync_convst (
      .clk(clk), .rst_n(reset_n), .d_i(adc.adc_convst),
      .level_o(convst_lvl), .rise_o(convst_rise), .fall_o(convst_fall_unused)
   );

   sync_edge #(.STAGES(2)) u_sync_sck (
      .clk(clk), .rst_n(reset_n), .d_i(adc.adc_sck),
      .level_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall)
   );

   sync_edge #(.STAGES(2)) u_sync_sdi (
      .clk(clk), .rst_n(reset_n), .d_i(adc.adc_sdi),
      .level_o(sdi_lvl), .rise_o(sdi_rise_unused), .fall_o(sdi_fall_unused)
   );

   logic [1:0]        state_q, state_d;
   logic [CC_W-1:0]   cc_q, cc_d;
   logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [CFG_W-1:0]  cfg_sh_q, cfg_sh_d;
   logic [CFG_W-1:0]  cfg_word_q, cfg_word_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              cfg_valid_q, cfg_valid_d;
   logic              busy_q, busy_d;
   logic              sdo_q, sdo_d;
   logic              sdo_en_q, sdo_en_d;
   logic              abort_q, abort_d;
   logic              overrun_q, overrun_d;

   logic [2:0]        ch_sel;
   logic [31:0]       ch_base;
   logic [IDX_W-1:0]  bit_idx;

   assign ch_sel  = cfg_to_ch(cfg_word_q);
   assign ch_base = 32'(ch_sel) * 32'(DATA_W);
   assign bit_idx = IDX_TOP - IDX_W'(bit_cnt_q);

   // Next-state logic: CONVST edges outrank SCK edges within a frame
   always_comb begin
      state_d     = state_q;
      cc_d        = cc_q;
      bit_cnt_d   = bit_cnt_q;
      cfg_sh_d    = cfg_sh_q;
      cfg_word_d  = cfg_word_q;
      result_d    = result_q;
      cfg_valid_d = 1'b0;
      busy_d      = busy_q;
      sdo_d       = sdo_q;
      sdo_en_d    = sdo_en_q;
      abort_d     = abort_q & ~clr_flags;
      overrun_d   = overrun_q & ~clr_flags;

      case (state_q)
         ST_IDLE: begin
            if (convst_rise) begin
               state_d = ST_CONV;
               busy_d  = 1'b1;
               cc_d    = CC_LOAD;
            end
         end
         ST_CONV: begin
            if (convst_rise) begin
               overrun_d = 1'b1;
            end
            if (cc_q == '0) begin
               result_d = ch_data[ch_base +: DATA_W];
               busy_d   = 1'b0;
               state_d  = ST_READY;
            end else begin
               cc_d = cc_q - CC_ONE;
            end
         end
         ST_READY: begin
            if (!convst_lvl) begin
               state_d   = ST_SHIFT;
               sdo_d     = result_q[DATA_W-1];
               sdo_en_d  = 1'b1;
               bit_cnt_d = '0;
            end
         end
         ST_SHIFT: begin
            if (convst_rise) begin
               if (bit_cnt_q < BC_DATA) begin
                  abort_d = 1'b1;
               end
               state_d  = ST_CONV;
               busy_d   = 1'b1;
               cc_d     = CC_LOAD;
               sdo_en_d = 1'b0;
               sdo_d    = 1'b0;
            end else if (sck_rise) begin
               if (bit_cnt_q < BC_CFG) begin
                  cfg_sh_d = {cfg_sh_q[CFG_W-2:0], sdi_lvl};
                  if (bit_cnt_q == BC_CFG_LAST) begin
                     cfg_word_d  = cfg_sh_d;
                     cfg_valid_d = 1'b1;
                  end
               end
               if (bit_cnt_q != BC_MAX) begin
                  bit_cnt_d = bit_cnt_q + BC_ONE;
               end
            end else if (sck_fall) begin
               sdo_d = (bit_cnt_q < BC_DATA) ? result_q[bit_idx] : 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset drops any partially received config
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cc_q        <= '0;
         bit_cnt_q   <= '0;
         cfg_sh_q    <= '0;
         cfg_word_q  <= RESET_CFG;
         result_q    <= '0;
         cfg_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         sdo_q       <= 1'b0;
         sdo_en_q    <= 1'b0;
         abort_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cc_q        <= cc_d;
         bit_cnt_q   <= bit_cnt_d;
         cfg_sh_q    <= cfg_sh_d;
         cfg_word_q  <= cfg_word_d;
         result_q    <= result_d;
         cfg_valid_q <= cfg_valid_d;
         busy_q      <= busy_d;
         sdo_q       <= sdo_d;
         sdo_en_q    <= sdo_en_d;
         abort_q     <= abort_d;
         overrun_q   <= overrun_d;
      end
   end

   assign adc.adc_sdo    = sdo_q;
   assign adc.adc_sdo_en = sdo_en_q;
   assign busy           = busy_q;
   assign cfg_word       = cfg_word_q;
   assign cfg_valid      = cfg_valid_q;
   assign frame_abort    = abort_q;
   assign overrun        = overrun_q;

endmodule
